// File: rtl/wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_stage                                                        |
// | Purpose  : MEM/WB pipeline register and writeback datapath of the RV32I    |
// |            core. Captures MEM-stage results, extends load data, selects    |
// |            the writeback source and drives the register-file write port    |
// |            one cycle later. The same value is exported as a forwarding     |
// |            source for the EX-stage bypass muxes.                           |
// | Optional : WB_RETIRE_CNT_EN -- adds the instret retired-instruction        |
// |            counter port (CNT_W bits wide).                                 |
// | Ports    : clk, reset_n (sync, active-low), stall, flush                   |
// |            mem_* : MEM-stage instruction fields (valid, reg_wen, rd,       |
// |                    wb_sel, funct3, alu_result, pc_plus4, rdata)            |
// |            rf_wen / rf_addr_d / rf_data_d : register-file write port       |
// |            fwd_valid / fwd_rd / fwd_data  : forwarding source (mirrors rf) |
// |            instret : retired-instruction count (optional)                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_reg_wen,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  input  logic [XLEN-1:0]  mem_rdata,
`ifdef WB_RETIRE_CNT_EN
  output logic [CNT_W-1:0] instret,
`endif
  output logic             rf_wen,
  output logic [4:0]       rf_addr_d,
  output logic [XLEN-1:0]  rf_data_d,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Stage register
  logic            stage_valid;
  logic            stage_reg_wen;
  logic [4:0]      stage_rd;
  logic [1:0]      stage_wb_sel;
  logic [2:0]      stage_funct3;
  logic [XLEN-1:0] stage_alu;
  logic [XLEN-1:0] stage_pc4;
  logic [XLEN-1:0] stage_rdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_valid   <= 1'b0;
      stage_reg_wen <= 1'b0;
      stage_rd      <= '0;
      stage_wb_sel  <= '0;
      stage_funct3  <= '0;
      stage_alu     <= '0;
      stage_pc4     <= '0;
      stage_rdata   <= '0;
    end else if (flush) begin
      // Only the valid bit matters for a squashed slot; the remaining
      // fields are left holding whatever they had.
      stage_valid   <= 1'b0;
    end else if (!stall) begin
      stage_valid   <= mem_valid;
      stage_reg_wen <= mem_reg_wen;
      stage_rd      <= mem_rd;
      stage_wb_sel  <= mem_wb_sel;
      stage_funct3  <= mem_funct3;
      stage_alu     <= mem_alu_result;
      stage_pc4     <= mem_pc_plus4;
      stage_rdata   <= mem_rdata;
    end
  end

  // Load extraction and extension, all from registered values so that
  // there is no path from mem_* to the write port.
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_data;

  always_comb begin
    load_byte = 8'h00;
    case (stage_alu[1:0])
      2'd0:    load_byte = stage_rdata[7:0];
      2'd1:    load_byte = stage_rdata[15:8];
      2'd2:    load_byte = stage_rdata[23:16];
      default: load_byte = stage_rdata[31:24];
    endcase
    // a[0] ignored: misaligned halfwords never reach this stage
    load_half = stage_alu[1] ? stage_rdata[31:16] : stage_rdata[15:0];

    load_data = stage_rdata;
    case (stage_funct3)
      F3_LB:   load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
      F3_LH:   load_data = {{(XLEN-16){load_half[15]}}, load_half};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, load_byte};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, load_half};
      default: load_data = stage_rdata;   // LW and the unused encodings
    endcase

    wb_data = '0;
    case (stage_wb_sel)
      SEL_ALU:  wb_data = stage_alu;
      SEL_LOAD: wb_data = load_data;
      SEL_PC4:  wb_data = stage_pc4;
      default:  wb_data = '0;             // reserved encoding writes nothing
    endcase
  end

  // x0 is hard-wired zero, and the reserved source never writes.
  logic write_en;
  assign write_en = stage_valid & stage_reg_wen & (stage_rd != 5'd0) &
                    (stage_wb_sel != 2'b11);

  assign rf_wen    = write_en;
  assign rf_addr_d = stage_rd;
  assign rf_data_d = wb_data;

  assign fwd_valid = write_en;
  assign fwd_rd    = stage_rd;
  assign fwd_data  = wb_data;

`ifdef WB_RETIRE_CNT_EN
  // An instruction retires on the edge where it leaves the stage; a stalled
  // instruction therefore counts once, a flushed one never enters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instret <= '0;
    end else if (stage_valid && !stall) begin
      instret <= instret + CNT_W'(1);
    end
  end
`else
  // Counter width is meaningless without the counter; keep it referenced.
  if (CNT_W < 1) begin : g_no_counter
  end
`endif

endmodule
`default_nettype wire
